// File: rtl/bp_pkg.sv
`default_nettype none
//==============================================================================
// bp_pkg: shared constants, checkpoint type and helpers for the gshare predictor.
// Revision: 1.0
//==============================================================================
package bp_pkg;

  localparam int SUPER_SCALAR_WIDTH = 2;
  localparam int DFLT_GHR_BITS      = 8;
  localparam int MAX_IDX_BITS       = 32;
  localparam int MAX_CTR_BITS       = 8;

  // One history word per lane, captured at lookup time (default geometry).
  typedef logic [SUPER_SCALAR_WIDTH-1:0][DFLT_GHR_BITS-1:0] ckpt_t;

  // Word-aligned PC bits folded with the (zero-extended) history.
  function automatic logic [MAX_IDX_BITS-1:0] pht_index(
    input logic [63:0]             pc,
    input logic [MAX_IDX_BITS-1:0] h,
    input int                      idx_bits
  );
    logic [MAX_IDX_BITS-1:0] mask;
    mask = (idx_bits >= MAX_IDX_BITS) ? '1 : ((32'd1 << idx_bits) - 32'd1);
    return (pc[33:2] ^ h) & mask;
  endfunction

  function automatic logic [MAX_CTR_BITS-1:0] sat_inc(
    input logic [MAX_CTR_BITS-1:0] c,
    input int                      ctr_bits
  );
    logic [MAX_CTR_BITS-1:0] top;
    top = MAX_CTR_BITS'((32'd1 << ctr_bits) - 32'd1);
    return (c == top) ? c : c + MAX_CTR_BITS'(1);
  endfunction

  function automatic logic [MAX_CTR_BITS-1:0] sat_dec(
    input logic [MAX_CTR_BITS-1:0] c,
    input int                      ctr_bits
  );
    logic [MAX_CTR_BITS-1:0] unused_width;
    unused_width = MAX_CTR_BITS'(ctr_bits);
    return (c == '0) ? c : c - MAX_CTR_BITS'(1) + (unused_width & '0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/ghr_ckpt_ring.sv
`default_nettype none
//==============================================================================
// ghr_ckpt_ring: circular FIFO of per-group history checkpoints with random
// read by id and truncate-to-id recovery. Revision: 1.0
//==============================================================================
module ghr_ckpt_ring
  import bp_pkg::*;
#(
  parameter  int LANES    = SUPER_SCALAR_WIDTH,
  parameter  int GHR_BITS = 8,
  parameter  int DEPTH    = 8,
  localparam int PW       = $clog2(DEPTH)
) (
  input  logic                               clk_in,
  input  logic                               rst_N_in,
  input  logic                               i_push,
  input  logic [LANES-1:0][GHR_BITS-1:0]     i_push_h,
  input  logic                               i_pop,
  input  logic                               i_trunc,
  input  logic [PW-1:0]                      i_trunc_id,
  input  logic [PW-1:0]                      i_rd_id,
  output logic [LANES-1:0][GHR_BITS-1:0]     o_rd_h,
  output logic [PW-1:0]                      o_tail,
  output logic                               o_full
);

  logic [LANES-1:0][GHR_BITS-1:0] r_mem [DEPTH];
  logic [PW-1:0]                  r_head;
  logic [PW-1:0]                  r_tail;
  logic [PW:0]                    r_count;

  logic                           w_full;
  logic                           w_pop;
  logic                           w_push;
  logic [PW-1:0]                  w_head_n;
  logic [PW:0]                    w_cnt_pop;
  logic [PW-1:0]                  w_dist;
  logic [PW-1:0]                  w_tail_n;
  logic [PW:0]                    w_count_n;

  assign w_full = (r_count == (PW+1)'(DEPTH));

  // Commit is applied before any truncation so recovery sees the new head.
  always_comb begin
    w_pop     = i_pop && (r_count != '0);
    w_push    = i_push && !i_trunc && !w_full;
    w_head_n  = r_head + PW'(w_pop);
    w_cnt_pop = r_count - (PW+1)'(w_pop);
    w_dist    = i_trunc_id - w_head_n + PW'(1);
    w_tail_n  = r_tail;
    w_count_n = r_count;
    if (i_trunc) begin
      w_tail_n = i_trunc_id + PW'(1);
      if (w_dist != '0) begin
        w_count_n = {1'b0, w_dist};
      end else if (w_cnt_pop == (PW+1)'(DEPTH)) begin
        w_count_n = w_cnt_pop;
      end else begin
        w_count_n = '0;
      end
    end else begin
      w_tail_n  = r_tail + PW'(w_push);
      w_count_n = w_cnt_pop + (PW+1)'(w_push);
    end
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      r_head  <= w_head_n;
      r_tail  <= w_tail_n;
      r_count <= w_count_n;
    end
  end

  always_ff @(posedge clk_in) begin
    if (w_push) begin
      r_mem[r_tail] <= i_push_h;
    end
  end

  assign o_rd_h = r_mem[i_rd_id];
  assign o_tail = r_tail;
  assign o_full = w_full;

endmodule
`default_nettype wire

// File: rtl/gshare_predictor.sv
`default_nettype none
//==============================================================================
// gshare_predictor: multi-lane gshare direction predictor with speculative GHR
// and per-group checkpoints for exact recovery. Revision: 1.0
//==============================================================================
module gshare_predictor
  import bp_pkg::*;
#(
  parameter  int LANES      = SUPER_SCALAR_WIDTH,
  parameter  int GHR_BITS   = 8,
  parameter  int IDX_BITS   = 10,
  parameter  int CTR_BITS   = 2,
  parameter  int CKPT_DEPTH = 8,
  localparam int CKW        = $clog2(CKPT_DEPTH),
  localparam int LNW        = (LANES > 1) ? $clog2(LANES) : 1
) (
  input  logic               clk_in,
  input  logic               rst_N_in,
  input  logic               lk_valid_in,
  input  logic [63:0]        lk_pc_in,
  input  logic [LANES-1:0]   lk_bcond_in,
  output logic               lk_ready_out,
  output logic               pr_valid_out,
  output logic [LANES-1:0]   pr_taken_out,
  output logic [CKW-1:0]     pr_ckpt_out,
  input  logic               rs_valid_in,
  input  logic [63:0]        rs_pc_in,
  input  logic [CKW-1:0]     rs_ckpt_in,
  input  logic [LNW-1:0]     rs_lane_in,
  input  logic               rs_taken_in,
  input  logic               rs_mispredict_in,
  input  logic               cm_valid_in
);

  localparam int                  PHT_N    = 1 << IDX_BITS;
  localparam logic [CTR_BITS-1:0] CTR_INIT = CTR_BITS'((1 << (CTR_BITS-1)) - 1);
  localparam logic [CTR_BITS-1:0] CTR_THR  = CTR_BITS'(1 << (CTR_BITS-1));

  logic [CTR_BITS-1:0]            r_pht [PHT_N];
  logic [GHR_BITS-1:0]            r_ghr;
  logic                           r_pr_valid;
  logic [LANES-1:0]               r_pr_taken;
  logic [CKW-1:0]                 r_pr_ckpt;

  logic [LANES-1:0][GHR_BITS-1:0] w_lk_h;
  logic [LANES-1:0]               w_lk_taken;
  logic [GHR_BITS-1:0]            w_lk_ghr;
  logic [GHR_BITS-1:0]            w_h;
  logic                           w_stop;
  logic [IDX_BITS-1:0]            w_idx;

  logic                           w_recover;
  logic                           w_accept;
  logic                           w_full;
  logic [CKW-1:0]                 w_tail;
  logic [LANES-1:0][GHR_BITS-1:0] w_rs_e;
  logic [GHR_BITS-1:0]            w_rs_h;
  logic [IDX_BITS-1:0]            w_rs_idx;
  logic [CTR_BITS-1:0]            w_rs_ctr;
  logic [CTR_BITS-1:0]            w_rs_ctr_n;

  // Lane chain: each lane sees the history left by the older bcond lanes;
  // the first predicted-taken lane ends the group.
  always_comb begin
    w_h        = r_ghr;
    w_stop     = 1'b0;
    w_idx      = '0;
    w_lk_h     = '0;
    w_lk_taken = '0;
    for (int i = 0; i < LANES; i++) begin
      w_lk_h[i] = w_h;
      w_idx     = IDX_BITS'(pht_index(lk_pc_in + 64'(4 * i), 32'(w_h), IDX_BITS));
      if (lk_bcond_in[i] && !w_stop) begin
        w_lk_taken[i] = (r_pht[w_idx] >= CTR_THR);
        w_h           = {w_h[GHR_BITS-2:0], w_lk_taken[i]};
        w_stop        = w_lk_taken[i];
      end
    end
    w_lk_ghr = w_h;
  end

  assign w_recover    = rs_valid_in && rs_mispredict_in;
  assign lk_ready_out = !w_full && !w_recover;
  assign w_accept     = lk_valid_in && lk_ready_out;

  ghr_ckpt_ring #(
    .LANES    (LANES),
    .GHR_BITS (GHR_BITS),
    .DEPTH    (CKPT_DEPTH)
  ) u_ring (
    .clk_in     (clk_in),
    .rst_N_in   (rst_N_in),
    .i_push     (w_accept),
    .i_push_h   (w_lk_h),
    .i_pop      (cm_valid_in),
    .i_trunc    (w_recover),
    .i_trunc_id (rs_ckpt_in),
    .i_rd_id    (rs_ckpt_in),
    .o_rd_h     (w_rs_e),
    .o_tail     (w_tail),
    .o_full     (w_full)
  );

  // Training uses the history the branch actually saw, not the current GHR.
  assign w_rs_h     = w_rs_e[rs_lane_in];
  assign w_rs_idx   = IDX_BITS'(pht_index(rs_pc_in, 32'(w_rs_h), IDX_BITS));
  assign w_rs_ctr   = r_pht[w_rs_idx];
  assign w_rs_ctr_n = rs_taken_in
                    ? CTR_BITS'(sat_inc(MAX_CTR_BITS'(w_rs_ctr), CTR_BITS))
                    : CTR_BITS'(sat_dec(MAX_CTR_BITS'(w_rs_ctr), CTR_BITS));

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      for (int k = 0; k < PHT_N; k++) begin
        r_pht[k] <= CTR_INIT;
      end
    end else if (rs_valid_in) begin
      r_pht[w_rs_idx] <= w_rs_ctr_n;
    end
  end

  always_ff @(posedge clk_in or negedge rst_N_in) begin
    if (!rst_N_in) begin
      r_ghr      <= '0;
      r_pr_valid <= 1'b0;
      r_pr_taken <= '0;
      r_pr_ckpt  <= '0;
    end else begin
      r_pr_valid <= w_accept;
      r_pr_taken <= w_accept ? w_lk_taken : '0;
      if (w_accept) begin
        r_pr_ckpt <= w_tail;
      end
      if (w_recover) begin
        r_ghr <= {w_rs_h[GHR_BITS-2:0], rs_taken_in};
      end else if (w_accept) begin
        r_ghr <= w_lk_ghr;
      end
    end
  end

  assign pr_valid_out = r_pr_valid;
  assign pr_taken_out = r_pr_taken;
  assign pr_ckpt_out  = r_pr_ckpt;

endmodule
`default_nettype wire

// File: tb/tb_gshare_predictor.sv
`default_nettype none
//==============================================================================
// tb_gshare_predictor: directed vector table, corner sequences and random
// stimulus against a behavioural model of the gshare predictor. Revision: 1.0
//==============================================================================
module tb_gshare_predictor;

  logic        clk_in = 1'b0;
  logic        rst_N_in = 1'b0;
  logic        lk_valid_in = 1'b0;
  logic [63:0] lk_pc_in = '0;
  logic [1:0]  lk_bcond_in = '0;
  logic        lk_ready_out;
  logic        pr_valid_out;
  logic [1:0]  pr_taken_out;
  logic [2:0]  pr_ckpt_out;
  logic        rs_valid_in = 1'b0;
  logic [63:0] rs_pc_in = '0;
  logic [2:0]  rs_ckpt_in = '0;
  logic [0:0]  rs_lane_in = '0;
  logic        rs_taken_in = 1'b0;
  logic        rs_mispredict_in = 1'b0;
  logic        cm_valid_in = 1'b0;

  gshare_predictor dut (
    .clk_in           (clk_in),
    .rst_N_in         (rst_N_in),
    .lk_valid_in      (lk_valid_in),
    .lk_pc_in         (lk_pc_in),
    .lk_bcond_in      (lk_bcond_in),
    .lk_ready_out     (lk_ready_out),
    .pr_valid_out     (pr_valid_out),
    .pr_taken_out     (pr_taken_out),
    .pr_ckpt_out      (pr_ckpt_out),
    .rs_valid_in      (rs_valid_in),
    .rs_pc_in         (rs_pc_in),
    .rs_ckpt_in       (rs_ckpt_in),
    .rs_lane_in       (rs_lane_in),
    .rs_taken_in      (rs_taken_in),
    .rs_mispredict_in (rs_mispredict_in),
    .cm_valid_in      (cm_valid_in)
  );

  always #5 clk_in = ~clk_in;

  int n_err = 0;
  int n_chk = 0;
  logic s_ready;

  // Reference model state
  int m_pht [1024];
  int m_ghr, m_head, m_tail, m_count, m_prc;
  int m_ckh [8][2];

  typedef struct {
    logic        lkv;
    logic [63:0] pc;
    logic [1:0]  bc;
    logic        rsv;
    logic [63:0] rpc;
    int          rck;
    int          rln;
    logic        rtk;
    logic        rmis;
    logic        cmv;
    logic        e_valid;
    logic [1:0]  e_taken;
    int          e_ckpt;
    int          e_ghr;
    int          e_pht0;
  } vec_t;

  vec_t tbl [8];

  function automatic vec_t mk(logic lkv, logic [63:0] pc, logic [1:0] bc, logic rsv,
                              logic [63:0] rpc, int rck, logic rtk, logic cmv,
                              logic ev, logic [1:0] et, int eck, int eg, int ep);
    vec_t v;
    v.lkv = lkv; v.pc = pc; v.bc = bc; v.rsv = rsv; v.rpc = rpc; v.rck = rck;
    v.rln = 0; v.rtk = rtk; v.rmis = 1'b0; v.cmv = cmv;
    v.e_valid = ev; v.e_taken = et; v.e_ckpt = eck; v.e_ghr = eg; v.e_pht0 = ep;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pidx(input logic [63:0] pc, input int h);
    return (int'(pc >> 2) ^ h) & 1023;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 1024; k++) m_pht[k] = 1;
    for (int k = 0; k < 8; k++) begin
      m_ckh[k][0] = 0;
      m_ckh[k][1] = 0;
    end
    m_ghr = 0; m_head = 0; m_tail = 0; m_count = 0; m_prc = 0;
  endtask

  // One clock of stimulus; the model advances with the spec's ordering rules.
  task automatic step(input logic lkv, input logic [63:0] pc, input logic [1:0] bc,
                      input logic rsv, input logic [63:0] rpc, input int rck, input int rln,
                      input logic rtk, input logic rmis, input logic cmv);
    int h, idx, e, d, t, stop, ntk, ready, acc;
    int nh [2];
    lk_valid_in = lkv; lk_pc_in = pc; lk_bcond_in = bc;
    rs_valid_in = rsv; rs_pc_in = rpc; rs_ckpt_in = 3'(rck); rs_lane_in = 1'(rln);
    rs_taken_in = rtk; rs_mispredict_in = rmis; cm_valid_in = cmv;
    #1;
    ready = (m_count < 8 && !(rsv && rmis)) ? 1 : 0;
    s_ready = lk_ready_out;
    chk("lk_ready", 64'(lk_ready_out), 64'(ready));
    acc = (lkv && ready != 0) ? 1 : 0;
    h = m_ghr; stop = 0; ntk = 0;
    for (int i = 0; i < 2; i++) begin
      nh[i] = h;
      if (bc[i] && stop == 0) begin
        idx = pidx(pc + 64'(4 * i), h);
        t = (m_pht[idx] >= 2) ? 1 : 0;
        ntk = ntk | (t << i);
        h = ((h << 1) | t) & 255;
        stop = t;
      end
    end
    e = 0;
    if (rsv) begin
      e = m_ckh[rck][rln];
      idx = pidx(rpc, e);
      if (rtk) m_pht[idx] = (m_pht[idx] == 3) ? 3 : m_pht[idx] + 1;
      else     m_pht[idx] = (m_pht[idx] == 0) ? 0 : m_pht[idx] - 1;
    end
    if (cmv && m_count > 0) begin
      m_head = (m_head + 1) % 8;
      m_count--;
    end
    if (acc != 0) begin
      m_ckh[m_tail][0] = nh[0];
      m_ckh[m_tail][1] = nh[1];
      m_prc = m_tail;
      m_tail = (m_tail + 1) % 8;
      m_count++;
      m_ghr = h;
    end
    if (rsv && rmis) begin
      m_ghr = ((e << 1) | int'(rtk)) & 255;
      m_tail = (rck + 1) % 8;
      d = (rck - m_head + 1) & 7;
      m_count = (d != 0) ? d : ((m_count == 8) ? 8 : 0);
    end
    @(posedge clk_in);
    #1;
    chk("pr_valid", 64'(pr_valid_out), 64'(acc));
    if (acc != 0) begin
      chk("pr_taken", 64'(pr_taken_out), 64'(ntk));
      chk("pr_ckpt", 64'(pr_ckpt_out), 64'(m_prc));
    end
    chk("ghr", 64'(dut.r_ghr), 64'(m_ghr));
    chk("count", 64'(dut.u_ring.r_count), 64'(m_count));
    chk("tail", 64'(dut.u_ring.r_tail), 64'(m_tail));
  endtask

  task automatic idle();
    step(1'b0, '0, 2'b00, 1'b0, '0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    lk_valid_in = 1'b0; rs_valid_in = 1'b0; rs_mispredict_in = 1'b0; cm_valid_in = 1'b0;
    rst_N_in = 1'b0;
    #3;
    rst_N_in = 1'b1;
    model_reset();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    int id, bitv, rck, rln;
    logic [63:0] pc, rpc;

    model_reset();
    #12;
    rst_N_in = 1'b1;
    @(posedge clk_in);
    #1;
    chk("rst_pr_valid", 64'(pr_valid_out), 64'd0);
    chk("rst_pr_taken", 64'(pr_taken_out), 64'd0);
    chk("rst_pr_ckpt", 64'(pr_ckpt_out), 64'd0);
    chk("rst_ready", 64'(lk_ready_out), 64'd1);
    chk("rst_ghr", 64'(dut.r_ghr), 64'd0);
    chk("rst_pht_last", 64'(dut.r_pht[1023]), 64'd1);

    // Directed vector table from reset.
    tbl[0] = mk(1, 64'h1000, 2'b01, 0, 64'h0,    0, 0, 0, 1, 2'b00, 0, 8'h00, 1);
    tbl[1] = mk(0, 64'h0,    2'b00, 1, 64'h1000, 0, 1, 0, 0, 2'b00, 0, 8'h00, 2);
    tbl[2] = mk(0, 64'h0,    2'b00, 1, 64'h1000, 0, 1, 0, 0, 2'b00, 0, 8'h00, 3);
    tbl[3] = mk(1, 64'h1000, 2'b01, 0, 64'h0,    0, 0, 0, 1, 2'b01, 1, 8'h01, 3);
    tbl[4] = mk(0, 64'h0,    2'b00, 1, 64'h1000, 0, 1, 0, 0, 2'b00, 1, 8'h01, 3);
    tbl[5] = mk(1, 64'h1004, 2'b11, 0, 64'h0,    0, 0, 0, 1, 2'b01, 2, 8'h03, 3);
    tbl[6] = mk(0, 64'h0,    2'b00, 0, 64'h0,    0, 0, 1, 0, 2'b00, 2, 8'h03, 3);
    tbl[7] = mk(1, 64'h1000, 2'b01, 0, 64'h0,    0, 0, 0, 1, 2'b00, 3, 8'h06, 3);
    for (int v = 0; v < 8; v++) begin
      step(tbl[v].lkv, tbl[v].pc, tbl[v].bc, tbl[v].rsv, tbl[v].rpc, tbl[v].rck,
           tbl[v].rln, tbl[v].rtk, tbl[v].rmis, tbl[v].cmv);
      chk("tbl_valid", 64'(pr_valid_out), 64'(tbl[v].e_valid));
      chk("tbl_taken", 64'(pr_taken_out), 64'(tbl[v].e_taken));
      chk("tbl_ckpt", 64'(pr_ckpt_out), 64'(tbl[v].e_ckpt));
      chk("tbl_ghr", 64'(dut.r_ghr), 64'(tbl[v].e_ghr));
      chk("tbl_pht0", 64'(dut.r_pht[0]), 64'(tbl[v].e_pht0));
    end

    // Asynchronous reset while a lookup is being presented.
    lk_valid_in = 1'b1; lk_pc_in = 64'h1000; lk_bcond_in = 2'b01;
    #2;
    rst_N_in = 1'b0;
    #1;
    chk("arst_pr_valid", 64'(pr_valid_out), 64'd0);
    chk("arst_pr_ckpt", 64'(pr_ckpt_out), 64'd0);
    chk("arst_ghr", 64'(dut.r_ghr), 64'd0);
    chk("arst_pht0", 64'(dut.r_pht[0]), 64'd1);
    chk("arst_count", 64'(dut.u_ring.r_count), 64'd0);
    do_reset();

    // Fill all checkpoints, then commit and commit+lookup.
    for (int k = 0; k < 8; k++) step(1, 64'h1200 + 64'(16 * k), 2'b00, 0, '0, 0, 0, 0, 0, 0);
    chk("full_count", 64'(dut.u_ring.r_count), 64'd8);
    step(1, 64'h1300, 2'b01, 0, '0, 0, 0, 0, 0, 0);
    chk("full_ready", 64'(s_ready), 64'd0);
    step(0, '0, 2'b00, 0, '0, 0, 0, 0, 0, 1);
    chk("cm_count", 64'(dut.u_ring.r_count), 64'd7);
    step(1, 64'h1300, 2'b01, 0, '0, 0, 0, 0, 0, 1);
    chk("cm_lk_valid", 64'(pr_valid_out), 64'd1);
    chk("cm_lk_count", 64'(dut.u_ring.r_count), 64'd7);
    step(1, 64'h1304, 2'b00, 0, '0, 0, 0, 0, 0, 0);
    chk("refill_count", 64'(dut.u_ring.r_count), 64'd8);
    for (int k = 0; k < 9; k++) step(0, '0, 2'b00, 0, '0, 0, 0, 0, 0, 1);
    chk("drain_count", 64'(dut.u_ring.r_count), 64'd0);

    // Build GHR = 0x5A one bit at a time through mispredict recovery.
    do_reset();
    for (int b = 7; b >= 0; b--) begin
      bitv = (8'h5A >> b) & 1;
      step(1, 64'h2000, 2'b00, 0, '0, 0, 0, 0, 0, 0);
      id = m_prc;
      step(0, '0, 2'b00, 1, 64'h2000, id, 0, 1'(bitv), 1, 0);
      step(0, '0, 2'b00, 0, '0, 0, 0, 0, 0, 1);
    end
    chk("ghr_5a", 64'(dut.r_ghr), 64'h5A);
    for (int k = 0; k < 6; k++) step(1, 64'h3000 + 64'(4 * k), 2'b00, 0, '0, 0, 0, 0, 0, 0);
    step(1, 64'h3000, 2'b01, 1, 64'h3000, 2, 0, 1, 1, 0);
    chk("mis_ready", 64'(s_ready), 64'd0);
    chk("mis_valid", 64'(pr_valid_out), 64'd0);
    chk("mis_ghr", 64'(dut.r_ghr), 64'hB5);
    chk("mis_tail", 64'(dut.u_ring.r_tail), 64'd3);
    chk("mis_count", 64'(dut.u_ring.r_count), 64'd3);

    // Randomised traffic against the model.
    for (int c = 0; c < 500; c++) begin
      pc  = 64'h1000 + 64'(4 * $urandom_range(0, 63));
      rpc = 64'h1000 + 64'(4 * $urandom_range(0, 63));
      rck = 0; rln = 0;
      if (m_count > 0 && $urandom_range(0, 2) == 0) begin
        rck = (m_head + $urandom_range(0, m_count - 1)) % 8;
        rln = $urandom_range(0, 1);
        step($urandom_range(0, 3) != 0, pc, 2'($urandom_range(0, 3)), 1, rpc, rck, rln,
             1'($urandom_range(0, 1)), $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0);
      end else begin
        step($urandom_range(0, 3) != 0, pc, 2'($urandom_range(0, 3)), 0, rpc, 0, 0,
             1'b0, 1'b0, $urandom_range(0, 2) == 0);
      end
    end
    idle();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
